rr_sel_arbiter: RTL and testbench



---
 rtl/rr_sel_arbiter.sv | 92 +++++++++
 tb/tb_rr_sel_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: holds the chosen input under a
// valid/ready handshake, with a watchdog that abandons grants never accepted.
module rr_sel_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] sel_out,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       tmo,
    output logic [7:0] xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit            WDOG_EN   = (TIMEOUT != 0);

    state_t        state;
    logic [1:0]    ptr;
    logic [TW-1:0] wait_cnt;
    logic [1:0]    pick_idx;
    logic [1:0]    cand;

    // Search downward so the candidate closest to ptr is the last one written.
    always_comb begin
        pick_idx = ptr;
        cand     = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) pick_idx = cand;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            wait_cnt <= '0;
            sel_out  <= 2'd0;
            gnt      <= 4'b0000;
            valid    <= 1'b0;
            tmo      <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            tmo <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        sel_out  <= pick_idx;
                        gnt      <= 4'b0001 << pick_idx;
                        valid    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= BUSY;
                    end else begin
                        valid <= 1'b0;
                        gnt   <= 4'b0000;
                    end
                end
                BUSY: begin
                    if (ready) begin
                        xfer_cnt <= xfer_cnt + 8'd1;
                        ptr      <= sel_out + 2'd1;
                        valid    <= 1'b0;
                        gnt      <= 4'b0000;
                        state    <= IDLE;
                    end else if (WDOG_EN && wait_cnt == WAIT_LAST) begin
                        // Skip the stalled channel so the others get a turn.
                        tmo   <= 1'b1;
                        ptr   <= sel_out + 2'd1;
                        valid <= 1'b0;
                        gnt   <= 4'b0000;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter with TIMEOUT=4; expected values are hand-derived.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel_out;
    logic [3:0] gnt;
    logic       valid;
    logic       tmo;
    logic [7:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;

    rr_sel_arbiter #(.TIMEOUT(4), .TW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ready    (ready),
        .sel_out  (sel_out),
        .gnt      (gnt),
        .valid    (valid),
        .tmo      (tmo),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [1:0] idx);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_sel"},   32'(sel_out), 32'(idx));
        check({tag, "_gnt"},   32'(gnt), 32'(4'b0001 << idx));
        check({tag, "_tmo"},   32'(tmo), 32'd0);
    endtask

    task automatic check_idle(input string tag, input logic [7:0] xc);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_gnt"},   32'(gnt), 32'd0);
        check({tag, "_xfer"},  32'(xfer_cnt), 32'(xc));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        #2;
        check("rst_sel",   32'(sel_out), 32'd0);
        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_tmo",   32'(tmo), 32'd0);
        check("rst_xfer",  32'(xfer_cnt), 32'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("idle_noreq", 8'd0);
        end

        // Priority from ptr=0: 1010 picks ch1, then ch3 after ptr advances to 2.
        req = 4'b1010;
        tick();
        check_grant("prio_ch1", 2'd1);
        ready = 1'b1;
        tick();
        check_idle("prio_xfer1", 8'd1);
        tick();
        check_grant("prio_ch3", 2'd3);
        tick();
        check_idle("prio_xfer2", 8'd2);

        // Rotation from ptr=0 with every channel requesting.
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("rot_grant", 2'(i));
            tick();
            check("rot_gap_valid", 32'(valid), 32'd0);
        end
        check("rot_xfer_after8", 32'(xfer_cnt), 32'd6);
        tick();
        check_grant("rot_wrap_ch0", 2'd0);
        tick();
        check_idle("rot_xfer7", 8'd7);

        // Watchdog: ptr=1, only ch0 requests, consumer stalls.
        req   = 4'b0001;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("wd_hold", 2'd0);
        end
        tick();
        check("wd_tmo", 32'(tmo), 32'd1);
        check_idle("wd_drop", 8'd7);
        tick();
        check_grant("wd_regrant", 2'd0);

        // Boundary: ready on the 4th busy cycle beats the watchdog; other req bits ignored.
        req = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("bnd_hold", 2'd0);
        end
        ready = 1'b1;
        tick();
        check("bnd_tmo", 32'(tmo), 32'd0);
        check_idle("bnd_xfer", 8'd8);

        // ptr=1, req=0100 -> ch2; then async reset mid-BUSY.
        req   = 4'b0100;
        ready = 1'b0;
        tick();
        check_grant("rstbusy_ch2", 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(valid), 32'd0);
        check("async_gnt",   32'(gnt), 32'd0);
        check("async_sel",   32'(sel_out), 32'd0);
        check("async_xfer",  32'(xfer_cnt), 32'd0);
        req = 4'b0000;
        #1;
        rst_n = 1'b1;

        // Counter wrap: 255 transfers then one more.
        req   = 4'b0001;
        ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            tick();
        end
        check("wrap_255", 32'(xfer_cnt), 32'd255);
        tick();
        check_grant("wrap_grant", 2'd0);
        tick();
        check("wrap_0", 32'(xfer_cnt), 32'd0);
        check("wrap_valid", 32'(valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
